// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA constants, arbiter state type and priority pick helper
package dma_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // First requesting channel scanning top, top+1, ... modulo NUM_CH.
  function automatic logic [1:0] pri_pick(input logic [NUM_CH-1:0] eff,
                                          input logic [1:0]        top);
    logic [1:0] idx;
    logic       found;
    pri_pick = top;
    found    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = top + 2'(i);
      if (!found && eff[idx]) begin
        pri_pick = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/dma_sync2.sv
// rtl/dma_sync2.sv - multi-stage flop synchronizer for asynchronous request pins
module dma_sync2 #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - DMA request merge, priority resolve and HRQ/HLDA bus sequencer
module dma_priority_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              n_RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              HLDA,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] sw_req,
  input  logic              rot_pri,
  input  logic              dreq_sense,
  input  logic              dack_sense,
  input  logic              ctrl_disable,
  input  logic              svc_done,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              active,
  output logic [1:0]        chan,
  output logic              sw_active
);
  import dma_pkg::*;

  arb_state_t        state;
  logic [NUM_CH-1:0] dreq_s;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] eff;
  logic              eff_any;
  logic [1:0]        winner;
  logic [1:0]        top;
  logic [NUM_CH-1:0] grant;

  dma_sync2 #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (NUM_CH)
  ) u_dreq_sync (
    .clk   (CLK),
    .rst_n (n_RESET),
    .d     (DREQ),
    .q     (dreq_s)
  );

  // Software requests bypass the mask so firmware can always kick a channel.
  always_comb begin
    req     = dreq_sense ? ~dreq_s : dreq_s;
    eff     = (req & ~mask) | sw_req;
    eff_any = |eff;
    winner  = pri_pick(eff, top);
  end

  always_ff @(posedge CLK or negedge n_RESET) begin
    if (!n_RESET) begin
      state     <= IDLE;
      HRQ       <= 1'b0;
      active    <= 1'b0;
      chan      <= '0;
      sw_active <= 1'b0;
      grant     <= '0;
      top       <= '0;
    end else begin
      if (!rot_pri) begin
        top <= '0;
      end
      case (state)
        IDLE: begin
          if (eff_any && !ctrl_disable) begin
            state <= REQ;
            HRQ   <= 1'b1;
          end
        end
        REQ: begin
          if (HLDA) begin
            if (eff_any) begin
              state     <= GRANT;
              chan      <= winner;
              sw_active <= sw_req[winner];
              active    <= 1'b1;
              grant     <= {{(NUM_CH-1){1'b0}}, 1'b1} << winner;
            end else begin
              state <= RELEASE;
              HRQ   <= 1'b0;
            end
          end else if (!eff_any || ctrl_disable) begin
            state <= IDLE;
            HRQ   <= 1'b0;
          end
        end
        GRANT: begin
          // Completion wins over a simultaneous HLDA drop so rotation is not lost.
          if (svc_done) begin
            if (rot_pri) begin
              top <= chan + 2'd1;
            end
            state     <= RELEASE;
            HRQ       <= 1'b0;
            active    <= 1'b0;
            sw_active <= 1'b0;
            grant     <= '0;
          end else if (!HLDA) begin
            state     <= IDLE;
            HRQ       <= 1'b0;
            active    <= 1'b0;
            sw_active <= 1'b0;
            grant     <= '0;
          end
        end
        RELEASE: begin
          if (!HLDA) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          HRQ   <= 1'b0;
        end
      endcase
    end
  end

  assign DACK = dack_sense ? grant : ~grant;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb/tb_dma_priority_arbiter.sv - directed self-checking bench for dma_priority_arbiter
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       n_RESET;
  logic [3:0] DREQ;
  logic       HLDA;
  logic [3:0] mask;
  logic [3:0] sw_req;
  logic       rot_pri;
  logic       dreq_sense;
  logic       dack_sense;
  logic       ctrl_disable;
  logic       svc_done;
  logic       HRQ;
  logic [3:0] DACK;
  logic       active;
  logic [1:0] chan;
  logic       sw_active;

  int checks = 0;
  int errors = 0;

  dma_priority_arbiter #(
    .NUM_CH      (4),
    .SYNC_STAGES (2)
  ) dut (
    .CLK          (CLK),
    .n_RESET      (n_RESET),
    .DREQ         (DREQ),
    .HLDA         (HLDA),
    .mask         (mask),
    .sw_req       (sw_req),
    .rot_pri      (rot_pri),
    .dreq_sense   (dreq_sense),
    .dack_sense   (dack_sense),
    .ctrl_disable (ctrl_disable),
    .svc_done     (svc_done),
    .HRQ          (HRQ),
    .DACK         (DACK),
    .active       (active),
    .chan         (chan),
    .sw_active    (sw_active)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_hrq(input string tag);
    int n = 0;
    while (HRQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(HRQ), 32'd1);
  endtask

  task automatic grant_cycle(input string tag, output logic [1:0] c);
    wait_hrq(tag);
    HLDA = 1'b1;
    tick();
    c = chan;
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    HLDA     = 1'b0;
    tick();
  endtask

  task automatic quiesce();
    DREQ   = 4'h0;
    sw_req = 4'h0;
    repeat (5) tick();
  endtask

  logic [1:0] got;
  logic [1:0] rot_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic       hrq_seen;

  initial begin
    n_RESET = 1'b0; DREQ = 4'h0; HLDA = 1'b0; mask = 4'h0; sw_req = 4'h0;
    rot_pri = 1'b0; dreq_sense = 1'b0; dack_sense = 1'b0; ctrl_disable = 1'b0; svc_done = 1'b0;
    #2;
    check("rst_hrq", 32'(HRQ), 32'd0);
    check("rst_dack", 32'(DACK), 32'hF);
    check("rst_active", 32'(active), 32'd0);
    check("rst_chan", 32'(chan), 32'd0);
    check("rst_sw_active", 32'(sw_active), 32'd0);
    repeat (2) tick();
    n_RESET = 1'b1;
    tick();

    // Fixed priority with exact DREQ-to-HRQ latency
    DREQ = 4'b1010;
    tick(); tick();
    check("fix_hrq_early", 32'(HRQ), 32'd0);
    tick();
    check("fix_hrq_lat", 32'(HRQ), 32'd1);
    tick(); tick();
    HLDA = 1'b1;
    tick();
    check("fix_chan", 32'(chan), 32'd1);
    check("fix_active", 32'(active), 32'd1);
    check("fix_dack", 32'(DACK), 32'b1101);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    check("fix_done_dack", 32'(DACK), 32'hF);
    check("fix_done_hrq", 32'(HRQ), 32'd0);
    check("fix_done_active", 32'(active), 32'd0);
    HLDA = 1'b0;
    tick();
    check("fix_idle_hrq", 32'(HRQ), 32'd0);
    tick();
    check("fix_rearm_hrq", 32'(HRQ), 32'd1);
    HLDA = 1'b1;
    tick();
    check("fix_chan2", 32'(chan), 32'd1);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    HLDA = 1'b0;
    tick();
    quiesce();

    // Rotating priority
    rot_pri = 1'b1;
    DREQ = 4'hF;
    for (int i = 0; i < 5; i++) begin
      grant_cycle("rot_hrq", got);
      check($sformatf("rot_chan%0d", i), 32'(got), 32'(rot_exp[i]));
    end
    wait_hrq("sim_hrq");
    HLDA = 1'b1;
    tick();
    check("sim_chan", 32'(chan), 32'd1);
    svc_done = 1'b1;
    HLDA = 1'b0;
    tick();
    svc_done = 1'b0;
    check("sim_hrq_low", 32'(HRQ), 32'd0);
    check("sim_active_low", 32'(active), 32'd0);
    tick();
    grant_cycle("sim_next_hrq", got);
    check("sim_rotated", 32'(got), 32'd2);
    wait_hrq("abort_hrq");
    HLDA = 1'b1;
    tick();
    check("abort_chan", 32'(chan), 32'd3);
    HLDA = 1'b0;
    tick();
    check("abort_active", 32'(active), 32'd0);
    check("abort_hrq", 32'(HRQ), 32'd0);
    grant_cycle("abort_next_hrq", got);
    check("abort_no_rot", 32'(got), 32'd3);
    rot_pri = 1'b0;
    quiesce();

    // Masked hardware request, then software request
    mask = 4'b0001;
    DREQ = 4'b0001;
    hrq_seen = 1'b0;
    repeat (10) begin
      tick();
      hrq_seen = hrq_seen | HRQ;
    end
    check("mask_hrq", 32'(hrq_seen), 32'd0);
    sw_req = 4'b0100;
    tick();
    check("sw_hrq", 32'(HRQ), 32'd1);
    HLDA = 1'b1;
    tick();
    check("sw_chan", 32'(chan), 32'd2);
    check("sw_active", 32'(sw_active), 32'd1);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    sw_req = 4'h0;
    HLDA = 1'b0;
    tick();
    mask = 4'h0;
    quiesce();

    // Inverted pin polarity
    dreq_sense = 1'b1;
    dack_sense = 1'b1;
    DREQ = 4'b1110;
    wait_hrq("pol_hrq");
    tick(); tick();
    HLDA = 1'b1;
    tick();
    check("pol_chan", 32'(chan), 32'd0);
    check("pol_dack", 32'(DACK), 32'b0001);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    HLDA = 1'b0;
    tick();
    n_RESET = 1'b0;
    #1;
    check("pol_rst_dack", 32'(DACK), 32'h0);
    DREQ = 4'h0;
    dreq_sense = 1'b0;
    dack_sense = 1'b0;
    tick();
    n_RESET = 1'b1;
    tick();

    // Request withdrawal and controller disable
    DREQ = 4'b0100;
    wait_hrq("wd_hrq");
    DREQ = 4'h0;
    tick(); tick();
    check("wd_hrq_hold", 32'(HRQ), 32'd1);
    tick();
    check("wd_hrq_drop", 32'(HRQ), 32'd0);
    check("wd_active", 32'(active), 32'd0);
    DREQ = 4'b0100;
    wait_hrq("dis_hrq");
    ctrl_disable = 1'b1;
    tick();
    check("dis_hrq_drop", 32'(HRQ), 32'd0);
    tick();
    check("dis_idle", 32'(HRQ), 32'd0);
    ctrl_disable = 1'b0;
    wait_hrq("dis_rearm");
    HLDA = 1'b1;
    tick();
    ctrl_disable = 1'b1;
    repeat (3) tick();
    check("dis_grant_held", 32'(active), 32'd1);
    check("dis_grant_dack", 32'(DACK), 32'b1011);
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
    check("dis_done_active", 32'(active), 32'd0);
    check("dis_done_hrq", 32'(HRQ), 32'd0);
    ctrl_disable = 1'b0;
    HLDA = 1'b0;
    tick();

    // Reset mid-grant clears rotation pointer
    rot_pri = 1'b1;
    grant_cycle("mid_hrq", got);
    check("mid_first", 32'(got), 32'd2);
    wait_hrq("mid_hrq2");
    HLDA = 1'b1;
    tick();
    check("mid_active", 32'(active), 32'd1);
    #2;
    n_RESET = 1'b0;
    #1;
    check("mid_rst_hrq", 32'(HRQ), 32'd0);
    check("mid_rst_dack", 32'(DACK), 32'hF);
    check("mid_rst_active", 32'(active), 32'd0);
    HLDA = 1'b0;
    DREQ = 4'hF;
    tick();
    n_RESET = 1'b1;
    grant_cycle("post_rst_hrq", got);
    check("post_rst_top", 32'(got), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
